// File: rtl/ucsbece154_icache_pkg.sv
// Shared types and constants for the instruction cache.
// Default geometry, field widths, FSM states, text base.
package ucsbece154_icache_pkg;

  localparam int NUM_SETS_DEF    = 8;
  localparam int BLOCK_WORDS_DEF = 4;

  localparam int OFF_BITS = $clog2(BLOCK_WORDS_DEF);
  localparam int IDX_BITS = $clog2(NUM_SETS_DEF);
  localparam int TAG_BITS = 32 - 2 - OFF_BITS - IDX_BITS;

  localparam logic [31:0] TEXT_START = 32'h00010000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT,
    S_FILL
  } icache_state_e;

endpackage

// File: rtl/ucsbece154_icache_fill_ctrl.sv
// Miss FSM, beat counter and critical-word-first sequencer.
// Ports: fetch/hit in, burst beat in; wr_en/wr_off/line_set out.
module ucsbece154_icache_fill_ctrl
  import ucsbece154_icache_pkg::*;
#(
  parameter  int NUM_SETS    = NUM_SETS_DEF,
  parameter  int BLOCK_WORDS = BLOCK_WORDS_DEF,
  localparam int OB          = $clog2(BLOCK_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          read_enable,
  input  logic          hit,
  input  logic [31:0]   read_address,
  input  logic          mem_data_ready,
  output icache_state_e state,
  output logic          mem_read_request,
  output logic [31:0]   miss_addr,
  output logic          wr_en,
  output logic [OB-1:0] wr_off,
  output logic          line_set
);

  localparam logic [OB:0] LAST_BEAT =
    (OB+1)'(BLOCK_WORDS - 1);

  icache_state_e state_q, state_d;
  logic [31:0]   miss_addr_q, miss_addr_d;
  logic [OB:0]   beat_q, beat_d;
  logic [OB-1:0] next_off_q, next_off_d;
  logic [OB-1:0] crit_off;
  logic [OB-1:0] nxt_off;

  assign crit_off  = miss_addr_q[OB+1:2];
  assign state     = state_q;
  assign miss_addr = miss_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      miss_addr_q <= '0;
      beat_q      <= '0;
      next_off_q  <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      beat_q      <= beat_d;
      next_off_q  <= next_off_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    miss_addr_d      = miss_addr_q;
    beat_d           = beat_q;
    next_off_d       = next_off_q;
    mem_read_request = 1'b0;
    wr_en            = 1'b0;
    wr_off           = crit_off;
    line_set         = 1'b0;
    nxt_off          = next_off_q + OB'(1);
    unique case (state_q)
      S_IDLE: begin
        if (read_enable && !hit) begin
          miss_addr_d = read_address & 32'hFFFF_FFFC;
          state_d     = S_REQUEST;
        end
      end
      S_REQUEST: begin
        mem_read_request = 1'b1;
        state_d          = S_WAIT;
      end
      S_WAIT: begin
        if (mem_data_ready) begin
          wr_en   = 1'b1;
          wr_off  = crit_off;
          beat_d  = (OB+1)'(1);
          // Remaining words ascend from 0, skipping the critical one.
          next_off_d = (crit_off == '0) ? OB'(1) : '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_data_ready) begin
          wr_en  = 1'b1;
          wr_off = next_off_q;
          beat_d = beat_q + (OB+1)'(1);
          if (nxt_off == crit_off) begin
            nxt_off = nxt_off + OB'(1);
          end
          next_off_d = nxt_off;
          if (beat_q == LAST_BEAT) begin
            line_set = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: rtl/ucsbece154_icache.sv
// Direct-mapped read-only I-cache with burst refill.
// Macro ICACHE_EARLY_RESTART_EN forwards the critical word.
module ucsbece154_icache
  import ucsbece154_icache_pkg::*;
#(
  parameter int NUM_SETS    = NUM_SETS_DEF,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReadEnable,
  input  logic [31:0] ReadAddress,
  output logic [31:0] Instruction,
  output logic        Ready,
  output logic        MemReadRequest,
  output logic [31:0] MemReadAddress,
  input  logic [31:0] MemDataIn,
  input  logic        MemDataReady
);

  localparam int OB = $clog2(BLOCK_WORDS);
  localparam int IB = $clog2(NUM_SETS);
  localparam int TB = 30 - OB - IB;

  logic [31:0]   addr_w;
  logic [OB-1:0] rd_off;
  logic [IB-1:0] rd_idx;
  logic [TB-1:0] rd_tag;

  logic [31:0]   miss_addr;
  logic [IB-1:0] m_idx;
  logic [TB-1:0] m_tag;

  icache_state_e state;
  logic          hit;
  logic          wr_en;
  logic [OB-1:0] wr_off;
  logic          line_set;

  logic [31:0]   data_mem [NUM_SETS][BLOCK_WORDS];
  logic [TB-1:0] tag_mem  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q, valid_d;

  assign addr_w = ReadAddress & 32'hFFFF_FFFC;
  assign rd_off = addr_w[OB+1:2];
  assign rd_idx = addr_w[OB+IB+1:OB+2];
  assign rd_tag = addr_w[31:OB+IB+2];
  assign m_idx  = miss_addr[OB+IB+1:OB+2];
  assign m_tag  = miss_addr[31:OB+IB+2];

  assign hit = valid_q[rd_idx] &&
               (tag_mem[rd_idx] == rd_tag);

  assign MemReadAddress = miss_addr;

  ucsbece154_icache_fill_ctrl #(
    .NUM_SETS    (NUM_SETS),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_fill (
    .clk              (clk),
    .rst_n            (reset),
    .read_enable      (ReadEnable),
    .hit              (hit),
    .read_address     (addr_w),
    .mem_data_ready   (MemDataReady),
    .state            (state),
    .mem_read_request (MemReadRequest),
    .miss_addr        (miss_addr),
    .wr_en            (wr_en),
    .wr_off           (wr_off),
    .line_set         (line_set)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[m_idx][wr_off] <= MemDataIn;
    end
    if (line_set) begin
      tag_mem[m_idx] <= m_tag;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (line_set) begin
      valid_d[m_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_comb begin
    Ready       = 1'b0;
    Instruction = 'x;
    if ((state == S_IDLE) && ReadEnable && hit) begin
      Ready       = 1'b1;
      Instruction = data_mem[rd_idx][rd_off];
    end
`ifdef ICACHE_EARLY_RESTART_EN
    if ((state == S_WAIT) && MemDataReady) begin
      Ready       = 1'b1;
      Instruction = MemDataIn;
    end
`else
`endif
  end

endmodule

// File: tb/tb_ucsbece154_icache.sv
// Directed bench for ucsbece154_icache.
// Table rows for a cold miss, tasks for corner cases.
module tb_ucsbece154_icache;
  import ucsbece154_icache_pkg::*;

  localparam int NS = 8;
  localparam int BW = 4;
  localparam int LB = BW * 4;
`ifdef ICACHE_EARLY_RESTART_EN
  localparam bit ER = 1'b1;
`else
  localparam bit ER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        re;
  logic [31:0] addr;
  logic        mdr;
  logic [31:0] md;
  logic [31:0] instr;
  logic        rdy;
  logic        req;
  logic [31:0] maddr;

  int total = 0;
  int bad   = 0;

  ucsbece154_icache #(
    .NUM_SETS    (NS),
    .BLOCK_WORDS (BW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ReadEnable     (re),
    .ReadAddress    (addr),
    .Instruction    (instr),
    .Ready          (rdy),
    .MemReadRequest (req),
    .MemReadAddress (maddr),
    .MemDataIn      (md),
    .MemDataReady   (mdr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        re;
    logic [31:0] addr;
    logic        mdr;
    logic [31:0] md;
    logic        e_rdy;
    logic        e_req;
    logic [31:0] e_maddr;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vec [10];

  function automatic logic [31:0] text(
    input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    return {w[15:0] ^ 16'h5A5A, w[15:0]};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic re_i,
                       input logic [31:0] a,
                       input logic mdr_i,
                       input logic [31:0] md_i);
    @(negedge clk);
    re   = re_i;
    addr = a;
    mdr  = mdr_i;
    md   = md_i;
    #1;
  endtask

  task automatic expect_out(input string nm,
                            input logic e_rdy,
                            input logic e_req,
                            input logic [31:0] e_ins);
    chk({nm, ".ready"}, 32'(rdy), 32'(e_rdy));
    chk({nm, ".req"}, 32'(req), 32'(e_req));
    if (e_rdy) chk({nm, ".instr"}, instr, e_ins);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    re    = 1'b0;
    mdr   = 1'b0;
    md    = '0;
    #1;
    chk("rst.ready", 32'(rdy), 32'd0);
    chk("rst.req", 32'(req), 32'd0);
    chk("rst.maddr", maddr, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic hit(input logic [31:0] a);
    drive(1'b1, a, 1'b0, '0);
    expect_out("hit", 1'b1, 1'b0, text(a));
  endtask

  task automatic fill_seq(input logic [31:0] a,
                          input int gap);
    logic [31:0] base;
    logic [31:0] w;
    int crit;
    int n;
    int ord [BW];
    base = a & ~32'(LB - 1);
    crit = int'((a >> 2) % BW);
    drive(1'b1, a, 1'b0, '0);
    expect_out("miss", 1'b0, 1'b0, '0);
    drive(1'b1, a, 1'b0, '0);
    expect_out("request", 1'b0, 1'b1, '0);
    chk("request.maddr", maddr, a & 32'hFFFF_FFFC);
    drive(1'b1, a, 1'b0, '0);
    expect_out("wait", 1'b0, 1'b0, '0);
    ord[0] = crit;
    n = 1;
    for (int j = 0; j < BW; j++) begin
      if (j != crit) begin
        ord[n] = j;
        n++;
      end
    end
    for (int k = 0; k < BW; k++) begin
      if (k == gap) begin
        drive(1'b1, a, 1'b0, 32'hDEAD_BEEF);
        expect_out("gap", 1'b0, 1'b0, '0);
      end
      w = base + 32'(ord[k] * 4);
      drive(1'b1, a, 1'b1, text(w));
      expect_out("beat", (k == 0) ? ER : 1'b0,
                 1'b0, text(w));
    end
    drive(1'b1, a, 1'b0, '0);
    expect_out("fill_hit", 1'b1, 1'b0, text(a));
  endtask

  initial begin
    re    = 1'b0;
    addr  = '0;
    mdr   = 1'b0;
    md    = '0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("init.ready", 32'(rdy), 32'd0);
    chk("init.req", 32'(req), 32'd0);
    chk("init.maddr", maddr, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    vec[0] = '{1'b1, TEXT_START, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0, 32'h0};
    vec[1] = '{1'b1, TEXT_START, 1'b0, 32'h0,
               1'b0, 1'b1, TEXT_START, 32'h0};
    vec[2] = '{1'b1, TEXT_START, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0, 32'h0};
    vec[3] = '{1'b1, TEXT_START, 1'b1,
               text(TEXT_START), ER, 1'b0, 32'h0,
               text(TEXT_START)};
    vec[4] = '{1'b1, TEXT_START, 1'b1,
               text(TEXT_START + 4), 1'b0, 1'b0,
               32'h0, 32'h0};
    vec[5] = '{1'b1, TEXT_START, 1'b1,
               text(TEXT_START + 8), 1'b0, 1'b0,
               32'h0, 32'h0};
    vec[6] = '{1'b1, TEXT_START, 1'b1,
               text(TEXT_START + 12), 1'b0, 1'b0,
               32'h0, 32'h0};
    vec[7] = '{1'b1, TEXT_START, 1'b0, 32'h0,
               1'b1, 1'b0, 32'h0, text(TEXT_START)};
    vec[8] = '{1'b1, TEXT_START + 4, 1'b0, 32'h0,
               1'b1, 1'b0, 32'h0,
               text(TEXT_START + 4)};
    vec[9] = '{1'b1, TEXT_START + 12, 1'b0, 32'h0,
               1'b1, 1'b0, 32'h0,
               text(TEXT_START + 12)};

    for (int i = 0; i < 10; i++) begin
      drive(vec[i].re, vec[i].addr,
            vec[i].mdr, vec[i].md);
      expect_out($sformatf("vec%0d", i), vec[i].e_rdy,
                 vec[i].e_req, vec[i].e_instr);
      if (vec[i].e_req)
        chk($sformatf("vec%0d.maddr", i),
            maddr, vec[i].e_maddr);
    end

    drive(1'b0, TEXT_START, 1'b0, '0);
    expect_out("re_low", 1'b0, 1'b0, '0);

    fill_seq(TEXT_START + NS * LB, -1);
    hit(TEXT_START + NS * LB + 4);
    fill_seq(TEXT_START, 3);

    do_reset();
    fill_seq(TEXT_START + 8, 2);
    hit(TEXT_START);
    hit(TEXT_START + 4);
    hit(TEXT_START + 8);
    hit(TEXT_START + 12);

    drive(1'b1, TEXT_START + 16, 1'b0, '0);
    drive(1'b1, TEXT_START + 16, 1'b0, '0);
    drive(1'b1, TEXT_START + 16, 1'b0, '0);
    drive(1'b1, TEXT_START + 16, 1'b1,
          text(TEXT_START + 16));
    drive(1'b1, TEXT_START + 16, 1'b1,
          text(TEXT_START + 20));
    do_reset();
    fill_seq(TEXT_START + 16, -1);

    drive(1'b0, TEXT_START + 32, 1'b1, 32'h1234_5678);
    expect_out("stray", 1'b0, 1'b0, '0);
    fill_seq(TEXT_START + 32, -1);

    do_reset();
    fill_seq(TEXT_START + 12, 1);
    hit(TEXT_START);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ucsbece154_icache.md
Name: ucsbece154_icache

Overview:
- Direct-mapped, read-only instruction cache; the initiator/consumer side of the instruction-memory burst interface.
- On a miss it issues a single-cycle read request and absorbs the critical-word-first burst of BLOCK_WORDS words into one line.
- Sits between the core fetch stage and the instruction memory.
- Hits return in the same cycle.

Parameters:
- NUM_SETS, 8, number of lines; power of 2.
- BLOCK_WORDS, 4, words per line/burst; power of 2, ≥2; must equal the memory burst length.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state.
- ReadEnable  in  1  core fetch request; core holds ReadAddress stable until Ready.
- ReadAddress  in  32  fetch byte address; bits [1:0] ignored.
- Instruction  out  32  fetched word; valid only when Ready=1, otherwise 32'bx.
- Ready  out  1  Instruction valid this cycle.
- MemReadRequest  out  1  one-cycle burst request.
- MemReadAddress  out  32  miss address, word-aligned, unmodified word offset.
- MemDataIn  in  32  burst data.
- MemDataReady  in  1  burst beat valid.

Behaviour:
- Address split: off=[OFF+1:2], OFF=log2(BLOCK_WORDS); idx=next log2(NUM_SETS) bits; tag=remaining upper bits.
- Storage: data array, tag array, valid bit per set. Data and tag arrays are not reset. Valid bits are cleared by reset.
- States: IDLE, REQUEST, WAIT, FILL.
- IDLE, ReadEnable=1:
  - hit = valid[idx] && tag match. On a hit, Ready=1 and Instruction=data[idx][off] combinationally (0-cycle latency).
  - On a miss, register miss_addr={ReadAddress[31:2],2'b00} and go to REQUEST.
- REQUEST: MemReadRequest=1 for exactly this cycle, with MemReadAddress=miss_addr. Then go to WAIT.
- WAIT: on MemDataReady, write data[miss idx][miss off] (the critical word), set beat_cnt=1, go to FILL.
- FILL:
  - Each MemDataReady beat writes the next word. Order after the critical word is ascending from word 0, skipping the critical word. Example: off=2 with 4 words gives 2,0,1,3.
  - After beat BLOCK_WORDS, write the tag, set valid, return to IDLE.
  - The next cycle hits if the core still presents the same address.
- Beats arrive on consecutive cycles. A missing beat (MemDataReady=0 in FILL) is tolerated: stay in FILL, no write.
- Ready=0 in REQUEST, WAIT and FILL, except as defined under Optional Feature.
- MemDataReady while in IDLE or REQUEST (no outstanding burst) is ignored.
- Miss latency: 1 (REQUEST) + memory T0 delay + BLOCK_WORDS beats + 1 (IDLE hit).
- Reset outputs: Ready=0, MemReadRequest=0, MemReadAddress=0. Instruction is x.
- Reset mid-fill: state goes to IDLE, all valid bits are cleared, and the partially written line stays invalid.
- ReadEnable=0 in IDLE: no action, Ready=0.
- The core must not change ReadAddress while Ready=0. Behaviour is undefined if it does.

Optional Feature:
- Macro: ICACHE_EARLY_RESTART_EN.
- With the macro: on the critical-word beat (WAIT, MemDataReady=1), Ready=1 and Instruction=MemDataIn in that cycle. Fill then continues. Further core requests are not served until the return to IDLE.
- Without the macro: no forwarding; Ready only from IDLE hits.

Decomposition:
- Shared package/header: the state encodings; localparams OFF_BITS, IDX_BITS, TAG_BITS; and TEXT_START (32'h00010000), shared with the memory model.
- Natural sub-module: ucsbece154_icache_fill_ctrl.
  - Contains the FSM, beat counter and fill-word-offset sequencer.
  - Outputs the write enable, write word offset and line-valid set.
  - The top level holds the arrays and the hit logic.

Test Plan:
- Cold miss: reset, then ReadEnable at 0x00010000 → one-cycle MemReadRequest with MemReadAddress=0x00010000; 4 beats fill words 0,1,2,3; Ready=1 with TEXT[0] in the first IDLE cycle after the fill.
- Critical-word order: miss at 0x00010008 → beats written to offsets 2,0,1,3. Subsequent hits at 0x00010000, 04, 08 and 0C return TEXT[0..3] with Ready in the same cycle and no MemReadRequest.
- Conflict: fill 0x00010000, then access 0x00010000+NUM_SETS*16 (same idx, different tag) → miss and refill. Re-access of 0x00010000 misses again.
- Reset mid-fill: assert reset after the 2nd beat → outputs go to reset values. Re-access of the same address issues a new request.
- Stray beat: pulse MemDataReady in IDLE → no array write, no Ready, and a later access still misses.
- ICACHE_EARLY_RESTART_EN: miss at 0x0001000C → Ready=1 with Instruction=TEXT[3] in the first-beat cycle. Without the macro, Ready=0 in that cycle.
